// File: rtl/sigmoid.sv
// Three-stage pipelined logistic sigmoid using the PLAN piecewise-linear approximation.
// Q3.12 signed input, Q1.15 unsigned output; shifts and adds only.
module sigmoid (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] x,
    output logic        out_valid,
    output logic [15:0] y
);

    logic [2:0]  valid_q;
    logic [15:0] a_q;
    logic        s1_q;
    logic [15:0] p_q;
    logic        s2_q;
    logic [15:0] a_next;
    logic [15:0] p_next;
    logic [15:0] y_next;

    // Two's-complement magnitude; 0x8000 maps to 32768, which fits unsigned 16 bits.
    always_comb begin
        a_next = x;
        if (x[15]) begin
            a_next = ~x + 16'd1;
        end
    end

    // PLAN segments on |x|; every sum stays below 65536 so 16-bit arithmetic is exact.
    always_comb begin
        p_next = 16'd0;
        if (a_q >= 16'd20480) begin
            p_next = 16'd32768;
        end else if (a_q >= 16'd9728) begin
            p_next = {2'b00, a_q[15:2]} + 16'd27648;
        end else if (a_q >= 16'd4096) begin
            p_next = a_q + 16'd20480;
        end else begin
            p_next = {a_q[14:0], 1'b0} + 16'd16384;
        end
    end

    always_comb begin
        y_next = p_q;
        if (s2_q) begin
            y_next = 16'd32768 - p_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 3'b000;
            a_q     <= 16'd0;
            s1_q    <= 1'b0;
            p_q     <= 16'd0;
            s2_q    <= 1'b0;
            y       <= 16'd0;
        end else begin
            valid_q <= {valid_q[1:0], in_valid};
            // Each rank loads only behind a valid sample, so y holds through gaps.
            if (in_valid) begin
                a_q  <= a_next;
                s1_q <= x[15];
            end
            if (valid_q[0]) begin
                p_q  <= p_next;
                s2_q <= s1_q;
            end
            if (valid_q[1]) begin
                y <= y_next;
            end
        end
    end

    assign out_valid = valid_q[2];

endmodule

// File: tb/tb_sigmoid.sv
// Bench for sigmoid: integer reference model, per-cycle compare process,
// directed segment/threshold/reset cases and randomized streams.
module tb_sigmoid;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] x        = 16'd0;
    logic        out_valid;
    logic [15:0] y;

    int n_cmp = 0;
    int n_err = 0;

    sigmoid dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x         (x),
        .out_valid (out_valid),
        .y         (y)
    );

    always #5 clk = ~clk;

    // Reference: real-number reading of the segment table using plain integers.
    function automatic logic [15:0] ref_y(input logic [15:0] xi);
        int v;
        int a;
        int p;
        v = $signed(xi);
        a = (v < 0) ? -v : v;
        if (a >= 20480)     p = 32768;
        else if (a >= 9728) p = a / 4 + 27648;
        else if (a >= 4096) p = a + 20480;
        else                p = 2 * a + 16384;
        if (v < 0) p = 32768 - p;
        return 16'(p);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a delay line of {valid, value}; expected y remembers the last valid value.
    logic [16:0] pipe[$] = '{17'd0, 17'd0};
    logic [16:0] model_e;
    logic        exp_ov = 1'b0;
    logic [15:0] exp_y  = 16'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe   = '{17'd0, 17'd0};
            exp_ov = 1'b0;
            exp_y  = 16'd0;
        end else begin
            pipe.push_back({in_valid, ref_y(x)});
            model_e = pipe.pop_front();
            exp_ov  = model_e[16];
            if (model_e[16]) exp_y = model_e[15:0];
        end
    end

    always @(negedge clk) begin
        check("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
        check("y", {16'd0, y}, {16'd0, exp_y});
    end

    logic [15:0] tx[14] = '{16'h0000, 16'h0800, 16'h1000, 16'h2000, 16'h2800, 16'h5000, 16'h7FFF,
                            16'hF000, 16'hD800, 16'h8000, 16'h0FFF, 16'h25FF, 16'h2600, 16'h4FFF};
    logic [15:0] ty[14] = '{16'h4000, 16'h5000, 16'h6000, 16'h7000, 16'h7600, 16'h8000, 16'h8000,
                            16'h2000, 16'h0A00, 16'h0000, 16'h5FFE, 16'h75FF, 16'h7580, 16'h7FFF};

    // One isolated sample; pins exact latency and hold-after-pulse against a literal.
    task automatic single_literal(input logic [15:0] xi, input logic [15:0] ye, input string name);
        @(negedge clk);
        in_valid = 1'b1;
        x        = xi;
        @(posedge clk);
        #1;
        @(negedge clk);
        in_valid = 1'b0;
        x        = 16'hAAAA;
        @(posedge clk);
        #1;
        check({name, "_early"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check({name, "_ov"}, {31'd0, out_valid}, 32'd1);
        check({name, "_y"}, {16'd0, y}, {16'd0, ye});
        @(posedge clk);
        #1;
        check({name, "_after"}, {31'd0, out_valid}, 32'd0);
        check({name, "_hold"}, {16'd0, y}, {16'd0, ye});
    endtask

    function automatic logic [15:0] pick_x();
        logic [15:0] base;
        logic [15:0] v;
        int sel;
        if ($urandom_range(0, 1) == 0) return 16'($urandom_range(0, 65535));
        sel  = $urandom_range(0, 2);
        base = (sel == 0) ? 16'd4096 : (sel == 1) ? 16'd9728 : 16'd20480;
        v    = base + 16'($urandom_range(0, 4)) - 16'd2;
        if ($urandom_range(0, 1) == 1) v = ~v + 16'd1;
        return v;
    endfunction

    initial begin
        logic [15:0] r;
        logic [16:0] sum;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check("reset_ov", {31'd0, out_valid}, 32'd0);
        check("reset_y", {16'd0, y}, 32'd0);

        // Pin the model to hand-computed values and to odd symmetry.
        for (int i = 0; i < 14; i++) check("model_lit", {16'd0, ref_y(tx[i])}, {16'd0, ty[i]});
        for (int i = 0; i < 20; i++) begin
            r = pick_x();
            if (r == 16'h8000) r = 16'h7FFF;
            sum = {1'b0, ref_y(r)} + {1'b0, ref_y(~r + 16'd1)};
            check("model_sym", {15'd0, sum}, 32'h8000);
        end

        @(negedge clk);
        rst_n = 1'b1;
        single_literal(16'h0000, 16'h4000, "midpoint");

        // Segment, symmetry and threshold values back to back.
        for (int i = 1; i < 14; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x        = tx[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);

        // Gapped stream.
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            x        = pick_x();
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (5) @(negedge clk);

        // Asynchronous reset with samples in flight.
        in_valid = 1'b1;
        x        = 16'h0800;
        @(negedge clk);
        x        = 16'h2000;
        @(negedge clk);
        x        = 16'hF000;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ov", {31'd0, out_valid}, 32'd0);
        check("midrst_y", {16'd0, y}, 32'd0);
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        single_literal(16'h1000, 16'h6000, "post_rst");
        repeat (3) @(negedge clk);

        // Randomized stream, mostly dense with occasional gaps.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            x        = pick_x();
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
